reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE_BIT, default 3, giving the log2 entry count (8 entries) and the tag width.
REQ-002 SHALL have one clock, clk_in, and a synchronous, active-high reset, rst_in.
REQ-003 SHALL have port clk_in, input, 1: system clock.
REQ-004 SHALL have port rst_in, input, 1: synchronous active-high reset.
REQ-005 SHALL have port rdy_in, input, 1: pause when low.
REQ-006 SHALL have issue ports, all inputs: issue_valid 1; issue_type 2 (00 REG, 01 BRANCH, 10 STORE, 11 reserved, treated as REG); issue_rd 5; issue_ready 1 (result known at issue); issue_val 32; issue_pred_taken 1; issue_alt_pc 32 (redirect PC if the prediction is wrong).
REQ-007 SHALL have issue status outputs: full 1; empty 1; issue_tag ROB_SIZE_BIT (tag given to the next accepted issue, equal to tail).
REQ-008 SHALL have writeback inputs: wb_valid 1; wb_tag ROB_SIZE_BIT; wb_val 32; wb_taken 1 (branch outcome).
REQ-009 SHALL have query ports x2 (n=1,2): qry_tagn input ROB_SIZE_BIT; qry_readyn output 1; qry_valn output 32.
REQ-010 SHALL have register-file commit outputs: rob_set_idx 5; rob_set_reg_val 32; rob_set_recorder ROB_SIZE_BIT.
REQ-011 SHALL have flush outputs: rob_clear 1; clear_pc 32.
REQ-012 SHALL have store commit outputs: commit_store 1; commit_tag ROB_SIZE_BIT.

Function
REQ-013 SHALL be a circular buffer with head, tail and count (ROB_SIZE_BIT+1 bits); full = (count == 2^ROB_SIZE_BIT); empty = (count == 0).
REQ-014 SHALL accept an issue when issue_valid && !full at the clock edge: write entry[tail] (valid=1, ready=issue_ready, val=issue_val, fields), then tail = tail+1 mod 2^ROB_SIZE_BIT. issue_valid while full SHALL be ignored without state change.
REQ-015 SHALL, on wb_valid, set entry[wb_tag].ready=1 and store val and taken. wb to an invalid entry SHALL be ignored.
REQ-016 SHALL commit at most one entry per cycle: when entry[head] is valid and ready (stored bit; no same-cycle writeback bypass to commit), invalidate it and advance head.
REQ-017 SHALL register all commit outputs; they SHALL be visible in the cycle after the commit edge, for exactly one cycle, and be 0 otherwise.
REQ-018 SHALL, for a REG commit, drive rob_set_idx=rd (0 if rd==0), rob_set_reg_val=val, rob_set_recorder=head tag.
REQ-019 SHALL, for a STORE commit, drive commit_store=1 and commit_tag=head tag, with rob_set_idx=0.
REQ-020 SHALL, for a BRANCH commit with taken==pred_taken, retire with no visible output.
REQ-021 SHALL, for a BRANCH commit with taken!=pred_taken, invalidate all entries and set head=tail=count=0 at that edge, then drive rob_clear=1 and clear_pc=alt_pc for one cycle. Issue and wb in the mispredict commit cycle SHALL be discarded.
REQ-022 SHALL ignore all issue and wb inputs while rob_clear is high.
REQ-023 SHALL update count by +issue_accepted -commit; simultaneous issue and commit SHALL leave count unchanged. full SHALL be evaluated from the pre-edge count, so a commit does not admit an issue in the same cycle.
REQ-024 SHALL compute query outputs combinationally: qry_readyn = entry valid && ready; qry_valn = entry val. When not ready, qry_valn SHALL be 0.
REQ-025 SHALL freeze all state while rdy_in is low, with registered outputs holding their values.

Reset
REQ-026 SHALL, on rst_in at the clock edge, clear all entries, head, tail and count; all registered outputs SHALL be 0; empty=1, full=0, issue_tag=0.
REQ-027 SHALL give rst_in priority over rdy_in and all other inputs, and a reset mid-operation SHALL discard all in-flight entries.

Configuration
REQ-028 SHALL, with macro ROB_WB_FORWARD_EN defined, additionally report a query as ready with qry_valn=wb_val when wb_valid && wb_tag==qry_tagn && entry valid in the same cycle. Without the macro, queries SHALL reflect stored state only.

Verification
REQ-029 SHALL cover: reset, issue REG rd=5 ready=1 val=0x11 -> issue_tag 0; two cycles later rob_set_idx=5, val=0x11, recorder=0 for one cycle.
REQ-030 SHALL cover: issue 8 non-ready entries -> full=1; a 9th issue is ignored and issue_tag stays 0; wb tag 0, val=7 -> next-next cycle commit idx/val=7; full drops.
REQ-031 SHALL cover: issue BRANCH pred=0, alt_pc=0x100, then REG rd=3; wb tag0 taken=1 -> rob_clear=1, clear_pc=0x100 for one cycle; REG rd=3 never commits; empty=1.
REQ-032 SHALL cover: STORE at tag 2 after two REG -> commit_store=1, commit_tag=2, rob_set_idx=0.
REQ-033 SHALL cover: qry_tag1=1 with wb_valid tag1 val=0x55 in the same cycle -> qry_ready1=1, val 0x55 with ROB_WB_FORWARD_EN; 0 without; both builds report 1 on the next cycle.
REQ-034 SHALL cover: rdy_in=0 for 3 cycles with a ready head -> no commit and outputs held; commit occurs after rdy_in returns high.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer that retires one entry per cycle in order and flushes on a branch mispredict.
// Define ROB_WB_FORWARD_EN to let query ports see a same-cycle writeback; without it, queries read stored state only.
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 3
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,

    input  logic                    issue_valid,
    input  logic [1:0]              issue_type,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_ready,
    input  logic [31:0]             issue_val,
    input  logic                    issue_pred_taken,
    input  logic [31:0]             issue_alt_pc,

    output logic                    full,
    output logic                    empty,
    output logic [ROB_SIZE_BIT-1:0] issue_tag,

    input  logic                    wb_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb_tag,
    input  logic [31:0]             wb_val,
    input  logic                    wb_taken,

    input  logic [ROB_SIZE_BIT-1:0] qry_tag1,
    output logic                    qry_ready1,
    output logic [31:0]             qry_val1,
    input  logic [ROB_SIZE_BIT-1:0] qry_tag2,
    output logic                    qry_ready2,
    output logic [31:0]             qry_val2,

    output logic [4:0]              rob_set_idx,
    output logic [31:0]             rob_set_reg_val,
    output logic [ROB_SIZE_BIT-1:0] rob_set_recorder,

    output logic                    rob_clear,
    output logic [31:0]             clear_pc,

    output logic                    commit_store,
    output logic [ROB_SIZE_BIT-1:0] commit_tag
);

    localparam int DEPTH = 1 << ROB_SIZE_BIT;

    typedef enum logic [1:0] {
        TYPE_REG    = 2'b00,
        TYPE_BRANCH = 2'b01,
        TYPE_STORE  = 2'b10,
        TYPE_RSVD   = 2'b11
    } rob_type_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic        taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

    rob_entry_t                r_entry [DEPTH];
    logic [ROB_SIZE_BIT-1:0]   r_head;
    logic [ROB_SIZE_BIT-1:0]   r_tail;
    logic [ROB_SIZE_BIT:0]     r_count;

    logic [4:0]                r_set_idx;
    logic [31:0]               r_set_reg_val;
    logic [ROB_SIZE_BIT-1:0]   r_set_recorder;
    logic                      r_rob_clear;
    logic [31:0]               r_clear_pc;
    logic                      r_commit_store;
    logic [ROB_SIZE_BIT-1:0]   r_commit_tag;

    rob_entry_t                w_head_entry;
    logic                      w_full;
    logic                      w_commit;
    logic                      w_mispredict;
    logic                      w_issue_acc;
    logic                      w_wb_acc;

    // Commit looks only at the stored ready bit, so a writeback to the head retires one cycle later.
    assign w_head_entry = r_entry[r_head];
    assign w_full       = (r_count == (ROB_SIZE_BIT+1)'(DEPTH));
    assign w_commit     = w_head_entry.valid && w_head_entry.ready;
    assign w_mispredict = w_commit && (w_head_entry.kind == TYPE_BRANCH) &&
                          (w_head_entry.taken != w_head_entry.pred_taken);
    assign w_issue_acc  = issue_valid && !w_full && !r_rob_clear && !w_mispredict;
    assign w_wb_acc     = wb_valid && !r_rob_clear && !w_mispredict && r_entry[wb_tag].valid;

    assign full             = w_full;
    assign empty            = (r_count == '0);
    assign issue_tag        = r_tail;
    assign rob_set_idx      = r_set_idx;
    assign rob_set_reg_val  = r_set_reg_val;
    assign rob_set_recorder = r_set_recorder;
    assign rob_clear        = r_rob_clear;
    assign clear_pc         = r_clear_pc;
    assign commit_store     = r_commit_store;
    assign commit_tag       = r_commit_tag;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the entry array is reset too, so nothing from before a reset can leak out through the query ports.
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_set_idx      <= '0;
            r_set_reg_val  <= '0;
            r_set_recorder <= '0;
            r_rob_clear    <= 1'b0;
            r_clear_pc     <= '0;
            r_commit_store <= 1'b0;
            r_commit_tag   <= '0;
        end else if (rdy_in) begin
            r_set_idx      <= '0;
            r_set_reg_val  <= '0;
            r_set_recorder <= '0;
            r_rob_clear    <= 1'b0;
            r_clear_pc     <= '0;
            r_commit_store <= 1'b0;
            r_commit_tag   <= '0;

            if (w_mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_entry[i].valid <= 1'b0;
                    r_entry[i].ready <= 1'b0;
                end
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_rob_clear <= 1'b1;
                r_clear_pc  <= w_head_entry.alt_pc;
            end else begin
                if (w_wb_acc) begin
                    r_entry[wb_tag].ready <= 1'b1;
                    r_entry[wb_tag].val   <= wb_val;
                    r_entry[wb_tag].taken <= wb_taken;
                end

                if (w_commit) begin
                    r_entry[r_head].valid <= 1'b0;
                    r_head                <= r_head + ROB_SIZE_BIT'(1);
                    case (w_head_entry.kind)
                        TYPE_BRANCH: ;
                        TYPE_STORE: begin
                            r_commit_store <= 1'b1;
                            r_commit_tag   <= r_head;
                        end
                        default: begin
                            r_set_idx      <= w_head_entry.rd;
                            r_set_reg_val  <= w_head_entry.val;
                            r_set_recorder <= r_head;
                        end
                    endcase
                end

                // The tail slot is invalid whenever an issue is accepted, so it never collides with the writeback above.
                if (w_issue_acc) begin
                    r_entry[r_tail] <= '{valid: 1'b1, ready: issue_ready, kind: rob_type_e'(issue_type),
                                         rd: issue_rd, val: issue_val, pred_taken: issue_pred_taken,
                                         taken: 1'b0, alt_pc: issue_alt_pc};
                    r_tail <= r_tail + ROB_SIZE_BIT'(1);
                end

                if (w_issue_acc && !w_commit) begin
                    r_count <= r_count + (ROB_SIZE_BIT+1)'(1);
                end else if (!w_issue_acc && w_commit) begin
                    r_count <= r_count - (ROB_SIZE_BIT+1)'(1);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a value before any condition, so no latch can be inferred here.
        qry_ready1 = r_entry[qry_tag1].valid && r_entry[qry_tag1].ready;
        qry_val1   = qry_ready1 ? r_entry[qry_tag1].val : '0;
        qry_ready2 = r_entry[qry_tag2].valid && r_entry[qry_tag2].ready;
        qry_val2   = qry_ready2 ? r_entry[qry_tag2].val : '0;
`ifdef ROB_WB_FORWARD_EN
        if (wb_valid && (wb_tag == qry_tag1) && r_entry[qry_tag1].valid) begin
            qry_ready1 = 1'b1;
            qry_val1   = wb_val;
        end
        if (wb_valid && (wb_tag == qry_tag2) && r_entry[qry_tag2].valid) begin
            qry_ready2 = 1'b1;
            qry_val2   = wb_val;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issue, writeback, commit, store, mispredict flush, query forwarding and stall.
module tb_reorder_buffer;

    localparam int RB = 3;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          issue_valid;
    logic [1:0]    issue_type;
    logic [4:0]    issue_rd;
    logic          issue_ready;
    logic [31:0]   issue_val;
    logic          issue_pred_taken;
    logic [31:0]   issue_alt_pc;
    logic          full;
    logic          empty;
    logic [RB-1:0] issue_tag;
    logic          wb_valid;
    logic [RB-1:0] wb_tag;
    logic [31:0]   wb_val;
    logic          wb_taken;
    logic [RB-1:0] qry_tag1;
    logic          qry_ready1;
    logic [31:0]   qry_val1;
    logic [RB-1:0] qry_tag2;
    logic          qry_ready2;
    logic [31:0]   qry_val2;
    logic [4:0]    rob_set_idx;
    logic [31:0]   rob_set_reg_val;
    logic [RB-1:0] rob_set_recorder;
    logic          rob_clear;
    logic [31:0]   clear_pc;
    logic          commit_store;
    logic [RB-1:0] commit_tag;

    int n_asserts  = 0;
    int n_failures = 0;

    reorder_buffer #(.ROB_SIZE_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_val(issue_val), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc),
        .full(full), .empty(empty), .issue_tag(issue_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_taken(wb_taken),
        .qry_tag1(qry_tag1), .qry_ready1(qry_ready1), .qry_val1(qry_val1),
        .qry_tag2(qry_tag2), .qry_ready2(qry_ready2), .qry_val2(qry_val2),
        .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
        .rob_set_recorder(rob_set_recorder),
        .rob_clear(rob_clear), .clear_pc(clear_pc),
        .commit_store(commit_store), .commit_tag(commit_tag)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] v, input logic pred, input logic [31:0] alt);
        issue_valid      = 1'b1;
        issue_type       = t;
        issue_rd         = rd;
        issue_ready      = rdy;
        issue_val        = v;
        issue_pred_taken = pred;
        issue_alt_pc     = alt;
    endtask

    task automatic set_wb(input logic [RB-1:0] t, input logic [31:0] v, input logic tk);
        wb_valid = 1'b1;
        wb_tag   = t;
        wb_val   = v;
        wb_taken = tk;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        issue_valid = 1'b0; issue_type = 2'b00; issue_rd = '0; issue_ready = 1'b0;
        issue_val = '0; issue_pred_taken = 1'b0; issue_alt_pc = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_taken = 1'b0;
        qry_tag1 = '0; qry_tag2 = '0;
        #1;
        tick();
        tick();
        rst_in = 1'b0;

        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_issue_tag", 32'(issue_tag), 0);
        check("rst_set_idx", 32'(rob_set_idx), 0);
        check("rst_clear", 32'(rob_clear), 0);
        check("rst_commit_store", 32'(commit_store), 0);

        // Ready REG at issue commits on the following edge.
        set_issue(2'b00, 5'd5, 1'b1, 32'h11, 1'b0, 32'h0);
        check("t1_issue_tag", 32'(issue_tag), 0);
        tick();
        idle();
        check("t1_not_empty", 32'(empty), 0);
        check("t1_no_commit_yet", 32'(rob_set_idx), 0);
        tick();
        check("t1_idx", 32'(rob_set_idx), 5);
        check("t1_val", rob_set_reg_val, 32'h11);
        check("t1_recorder", 32'(rob_set_recorder), 0);
        tick();
        check("t1_idx_pulse", 32'(rob_set_idx), 0);
        check("t1_val_pulse", rob_set_reg_val, 0);
        check("t1_empty", 32'(empty), 1);

        // Fill all 8 slots, then try a 9th.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_issue(2'b00, 5'd7, 1'b0, 32'h0, 1'b0, 32'h0);
            check("t2_fill_tag", 32'(issue_tag), 32'(i));
            tick();
        end
        check("t2_full", 32'(full), 1);
        check("t2_tag_wrap", 32'(issue_tag), 0);
        set_issue(2'b00, 5'd9, 1'b1, 32'hDEAD, 1'b0, 32'h0);
        tick();
        idle();
        check("t2_9th_tag", 32'(issue_tag), 0);
        check("t2_9th_full", 32'(full), 1);
        set_wb(3'd0, 32'h7, 1'b0);
        tick();
        idle();
        check("t2_wb_no_commit", 32'(rob_set_idx), 0);
        check("t2_still_full", 32'(full), 1);
        tick();
        check("t2_idx", 32'(rob_set_idx), 7);
        check("t2_val", rob_set_reg_val, 32'h7);
        check("t2_recorder", 32'(rob_set_recorder), 0);
        check("t2_full_drop", 32'(full), 0);

        // Mispredicted branch flushes the younger REG and any same-cycle issue.
        do_reset();
        set_issue(2'b01, 5'd0, 1'b0, 32'h0, 1'b0, 32'h100);
        tick();
        set_issue(2'b00, 5'd3, 1'b1, 32'h33, 1'b0, 32'h0);
        tick();
        idle();
        set_wb(3'd0, 32'h0, 1'b1);
        tick();
        idle();
        check("t3_no_clear_yet", 32'(rob_clear), 0);
        set_issue(2'b00, 5'd9, 1'b1, 32'h99, 1'b0, 32'h0);
        tick();
        check("t3_clear", 32'(rob_clear), 1);
        check("t3_clear_pc", clear_pc, 32'h100);
        check("t3_empty", 32'(empty), 1);
        check("t3_tag_reset", 32'(issue_tag), 0);
        tick();
        idle();
        check("t3_clear_pulse", 32'(rob_clear), 0);
        check("t3_clear_pc_pulse", clear_pc, 0);
        check("t3_ignored_issue", 32'(empty), 1);
        check("t3_no_reg_commit", 32'(rob_set_idx), 0);
        tick();
        check("t3_rd3_never", 32'(rob_set_idx), 0);
        check("t3_empty_after", 32'(empty), 1);

        // Two REGs then a STORE at tag 2, all ready at issue.
        do_reset();
        set_issue(2'b00, 5'd1, 1'b1, 32'hA, 1'b0, 32'h0);
        tick();
        set_issue(2'b00, 5'd2, 1'b1, 32'hB, 1'b0, 32'h0);
        tick();
        check("t4_reg1_idx", 32'(rob_set_idx), 1);
        check("t4_reg1_val", rob_set_reg_val, 32'hA);
        set_issue(2'b10, 5'd6, 1'b1, 32'hC, 1'b0, 32'h0);
        check("t4_store_tag", 32'(issue_tag), 2);
        tick();
        idle();
        check("t4_reg2_idx", 32'(rob_set_idx), 2);
        check("t4_reg2_rec", 32'(rob_set_recorder), 1);
        tick();
        check("t4_commit_store", 32'(commit_store), 1);
        check("t4_commit_tag", 32'(commit_tag), 2);
        check("t4_store_idx", 32'(rob_set_idx), 0);
        tick();
        check("t4_store_pulse", 32'(commit_store), 0);

        // Query during a same-cycle writeback.
        do_reset();
        set_issue(2'b00, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        set_issue(2'b00, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        qry_tag1 = 3'd1;
        qry_tag2 = 3'd0;
        set_wb(3'd1, 32'h55, 1'b0);
        #1;
`ifdef ROB_WB_FORWARD_EN
        check("t5_fwd_ready", 32'(qry_ready1), 1);
        check("t5_fwd_val", qry_val1, 32'h55);
`else
        check("t5_fwd_ready", 32'(qry_ready1), 0);
        check("t5_fwd_val", qry_val1, 0);
`endif
        check("t5_q2_ready", 32'(qry_ready2), 0);
        check("t5_q2_val", qry_val2, 0);
        tick();
        idle();
        check("t5_stored_ready", 32'(qry_ready1), 1);
        check("t5_stored_val", qry_val1, 32'h55);

        // Stall with a ready head: outputs hold, commit resumes afterwards.
        set_wb(3'd0, 32'h44, 1'b0);
        tick();
        idle();
        tick();
        check("t6_idx", 32'(rob_set_idx), 4);
        check("t6_val", rob_set_reg_val, 32'h44);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold_idx", 32'(rob_set_idx), 4);
            check("t6_hold_rec", 32'(rob_set_recorder), 0);
        end
        check("t6_hold_not_empty", 32'(empty), 0);
        rdy_in = 1'b1;
        tick();
        check("t6_resume_idx", 32'(rob_set_idx), 5);
        check("t6_resume_val", rob_set_reg_val, 32'h55);
        check("t6_resume_rec", 32'(rob_set_recorder), 1);
        tick();
        check("t6_done_empty", 32'(empty), 1);

        // Reset wins over a low rdy_in and drops in-flight entries.
        set_issue(2'b00, 5'd8, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        idle();
        check("t7_pending", 32'(empty), 0);
        rdy_in = 1'b0;
        do_reset();
        check("t7_rst_empty", 32'(empty), 1);
        check("t7_rst_tag", 32'(issue_tag), 0);
        check("t7_rst_idx", 32'(rob_set_idx), 0);
        rdy_in = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
